eight_bit_sequential_divider: RTL

EIGHT_BIT_SEQUENTIAL_DIVIDER -- requirements
Module: eight_bit_sequential_divider

---
 rtl/eight_bit_sequential_divider.sv | 137 +++++++++++++
 1 files changed

// File: rtl/eight_bit_sequential_divider.sv
// Restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are flagged immediately, without iterating.
module eight_bit_sequential_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] P,
  input  logic [7:0]  B,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] b_q, b_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic       div_zero_q, div_zero_d;
  logic       overflow_q, overflow_d;

  logic [8:0] step_t;
  logic       step_ge;
  logic [7:0] step_rem;
  logic [7:0] step_quo;

  // rem < B always holds, so t < 2*B and t - B fits in 8 bits whenever t >= B
  always_comb begin
    step_t   = {rem_q, dvd_q[7]};
    step_ge  = (step_t >= {1'b0, b_q});
    step_rem = step_ge ? (step_t[7:0] - b_q) : step_t[7:0];
    step_quo = {quo_q[6:0], step_ge};
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d = B;
          if (B == 8'd0) begin
            q_d        = '1;
            r_d        = '1;
            div_zero_d = 1'b1;
            overflow_d = 1'b0;
            state_d    = S_DONE;
          end else if (P[15:8] >= B) begin
            q_d        = '1;
            r_d        = '1;
            div_zero_d = 1'b0;
            overflow_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            rem_d      = P[15:8];
            dvd_d      = P[7:0];
            quo_d      = '0;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            overflow_d = 1'b0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        dvd_d = {dvd_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_d     = step_quo;
          r_d     = step_rem;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q;
  assign overflow = overflow_q;

endmodule
